// File: rtl/cpu_isa_pkg.sv
// Shared ISA constants (op indices, opcodes, funcs, field positions) and the pure
// instruction encode function; the same constants serve the ALU control decoder.
package cpu_isa_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_MUL  = 5'd2;
    localparam logic [4:0] OP_SL   = 5'd3;
    localparam logic [4:0] OP_SR   = 5'd4;
    localparam logic [4:0] OP_SLA  = 5'd5;
    localparam logic [4:0] OP_SRA  = 5'd6;
    localparam logic [4:0] OP_JR   = 5'd7;
    localparam logic [4:0] OP_MOV  = 5'd8;
    localparam logic [4:0] OP_AND  = 5'd9;
    localparam logic [4:0] OP_OR   = 5'd10;
    localparam logic [4:0] OP_XOR  = 5'd11;
    localparam logic [4:0] OP_SLT  = 5'd12;
    localparam logic [4:0] OP_ADDI = 5'd13;
    localparam logic [4:0] OP_SUBI = 5'd14;
    localparam logic [4:0] OP_MULI = 5'd15;
    localparam logic [4:0] OP_LW   = 5'd16;
    localparam logic [4:0] OP_SW   = 5'd17;
    localparam logic [4:0] OP_BEQ  = 5'd18;
    localparam logic [4:0] OP_BRG  = 5'd19;
    localparam logic [4:0] OP_BRL  = 5'd20;
    localparam logic [4:0] OP_BNE  = 5'd21;
    localparam logic [4:0] OP_BRZ  = 5'd22;
    localparam logic [4:0] OP_JMP  = 5'd23;
    localparam logic [4:0] OP_JAL  = 5'd24;
    localparam logic [4:0] OP_ANDI = 5'd25;
    localparam logic [4:0] OP_ORI  = 5'd26;
    localparam logic [4:0] OP_XORI = 5'd27;
    localparam logic [4:0] OP_SLTI = 5'd28;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_MUL = 6'b100101;
    localparam logic [5:0] FN_SL  = 6'b000111;
    localparam logic [5:0] FN_SR  = 6'b000110;
    localparam logic [5:0] FN_SLA = 6'b110100;
    localparam logic [5:0] FN_SRA = 6'b110110;
    localparam logic [5:0] FN_JR  = 6'b000001;
    localparam logic [5:0] FN_MOV = 6'b000011;
    localparam logic [5:0] FN_AND = 6'b111000;
    localparam logic [5:0] FN_OR  = 6'b111001;
    localparam logic [5:0] FN_XOR = 6'b111010;
    localparam logic [5:0] FN_SLT = 6'b110011;

    localparam logic [5:0] OPC_ADDI = 6'b100011;
    localparam logic [5:0] OPC_SUBI = 6'b110001;
    localparam logic [5:0] OPC_MULI = 6'b111000;
    localparam logic [5:0] OPC_LW   = 6'b010001;
    localparam logic [5:0] OPC_SW   = 6'b011001;
    localparam logic [5:0] OPC_BEQ  = 6'b100000;
    localparam logic [5:0] OPC_BRG  = 6'b100010;
    localparam logic [5:0] OPC_BRL  = 6'b100101;
    localparam logic [5:0] OPC_BNE  = 6'b000111;
    localparam logic [5:0] OPC_BRZ  = 6'b000110;
    localparam logic [5:0] OPC_ANDI = 6'b001111;
    localparam logic [5:0] OPC_ORI  = 6'b001110;
    localparam logic [5:0] OPC_XORI = 6'b001100;
    localparam logic [5:0] OPC_SLTI = 6'b001000;
    localparam logic [5:0] OPC_JMP  = 6'b110100;
    localparam logic [5:0] OPC_JAL  = 6'b111110;

    localparam int unsigned OPC_LSB   = 26;
    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned RD_LSB    = 11;
    localparam int unsigned SHAMT_LSB = 6;
    localparam int unsigned FUNC_LSB  = 0;

    typedef struct packed {
        logic        rtype;
        logic [31:0] word;
    } enc_t;

    function automatic logic op_is_legal(input logic [4:0] op);
        return op <= OP_SLTI;
    endfunction

    // Illegal ops fall through every branch and encode as an all-zero NOP.
    function automatic enc_t encode(input logic [4:0] op, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic [4:0] rd,
                                    input logic [25:0] imm);
        enc_t       e;
        logic [5:0] fn;
        logic [5:0] opc;
        logic [4:0] shamt;
        e     = '0;
        fn    = '0;
        opc   = '0;
        shamt = '0;
        case (op)
            OP_ADD:  fn = FN_ADD;
            OP_SUB:  fn = FN_SUB;
            OP_MUL:  fn = FN_MUL;
            OP_SL:   begin fn = FN_SL;  shamt = imm[4:0]; end
            OP_SR:   begin fn = FN_SR;  shamt = imm[4:0]; end
            OP_SLA:  begin fn = FN_SLA; shamt = imm[4:0]; end
            OP_SRA:  begin fn = FN_SRA; shamt = imm[4:0]; end
            OP_JR:   fn = FN_JR;
            OP_MOV:  fn = FN_MOV;
            OP_AND:  fn = FN_AND;
            OP_OR:   fn = FN_OR;
            OP_XOR:  fn = FN_XOR;
            OP_SLT:  fn = FN_SLT;
            OP_ADDI: opc = OPC_ADDI;
            OP_SUBI: opc = OPC_SUBI;
            OP_MULI: opc = OPC_MULI;
            OP_LW:   opc = OPC_LW;
            OP_SW:   opc = OPC_SW;
            OP_BEQ:  opc = OPC_BEQ;
            OP_BRG:  opc = OPC_BRG;
            OP_BRL:  opc = OPC_BRL;
            OP_BNE:  opc = OPC_BNE;
            OP_BRZ:  opc = OPC_BRZ;
            OP_JMP:  opc = OPC_JMP;
            OP_JAL:  opc = OPC_JAL;
            OP_ANDI: opc = OPC_ANDI;
            OP_ORI:  opc = OPC_ORI;
            OP_XORI: opc = OPC_XORI;
            OP_SLTI: opc = OPC_SLTI;
            default: ;
        endcase
        if (op <= OP_SLT) begin
            e.rtype = 1'b1;
            e.word  = {OPC_RTYPE, rs, rt, rd, shamt, fn};
        end else if (op == OP_JMP || op == OP_JAL) begin
            e.word = {opc, imm};
        end else if (op <= OP_SLTI) begin
            e.word = {opc, rs, rt, imm[15:0]};
        end
        return e;
    endfunction

endpackage

// File: rtl/instr_enc_fifo.sv
// Synchronous FIFO with async active-high reset; push is ignored when full and pop
// when empty, so callers may pass raw handshake terms.
module instr_enc_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 33,
    parameter int unsigned CW    = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/instr_encoder.sv
// Buffered instruction encoder: op index + fields in, queued 32-bit words out.
// Define INSTR_ENC_ILLEGAL_TRAP_EN to drop illegal ops and raise sticky err instead of queueing NOPs.
module instr_encoder
    import cpu_isa_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_op,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic [25:0]   in_imm,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_word,
    output logic          out_rtype,
    output logic [CW-1:0] count,
    output logic          err
);

    enc_t enc_in;
    enc_t enc_head;
    logic accept;
    logic push;
    logic full;
    logic empty;

    assign enc_in = encode(in_op, in_rs, in_rt, in_rd, in_imm);
    // No pop-through: acceptance depends only on the current fill level.
    assign accept = in_valid && !full;

`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
    logic err_q, err_d;

    assign push = accept && op_is_legal(in_op);

    always_comb begin
        err_d = err_q | (accept && !op_is_legal(in_op));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err = err_q;
`else
    assign push = accept;
    assign err  = 1'b0;
`endif

    instr_enc_fifo #(
        .DEPTH(DEPTH),
        .WIDTH($bits(enc_t)),
        .CW   (CW)
    ) u_fifo (
        .clk_i  (clk),
        .rst_i  (rst),
        .push_i (push),
        .wdata_i(enc_in),
        .pop_i  (out_ready),
        .rdata_o(enc_head),
        .full_o (full),
        .empty_o(empty),
        .count_o(count)
    );

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_word  = empty ? 32'h0 : enc_head.word;
    assign out_rtype = empty ? 1'b0 : enc_head.rtype;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed and random checks of instr_encoder against a table-driven encoding model
// and a queue-based FIFO model.
module tb_instr_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_op = '0, in_rs = '0, in_rt = '0, in_rd = '0;
    logic [25:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_word;
    logic        out_rtype;
    logic [2:0]  count;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] mq[$];
    logic        err_m = 1'b0;
    bit          trap_en;

    int func_tab [13] = '{6'b100000, 6'b100010, 6'b100101, 6'b000111, 6'b000110, 6'b110100,
                          6'b110110, 6'b000001, 6'b000011, 6'b111000, 6'b111001, 6'b111010,
                          6'b110011};
    int opc_tab [29] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                         6'b100011, 6'b110001, 6'b111000, 6'b010001, 6'b011001, 6'b100000,
                         6'b100010, 6'b100101, 6'b000111, 6'b000110, 6'b110100, 6'b111110,
                         6'b001111, 6'b001110, 6'b001100, 6'b001000};

    instr_encoder #(.DEPTH(4), .CW(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_rs    (in_rs),
        .in_rt    (in_rt),
        .in_rd    (in_rd),
        .in_imm   (in_imm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_word (out_word),
        .out_rtype(out_rtype),
        .count    (count),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Model: {rtype, word} from plain field arithmetic.
    function automatic logic [32:0] ref_enc(int op, int rs, int rt, int rd, logic [25:0] imm);
        logic [31:0] w;
        int sh;
        if (op <= 12) begin
            sh = (op >= 3 && op <= 6) ? int'(imm % 32) : 0;
            w = 32'(rs) * 32'h200000 + 32'(rt) * 32'h10000 + 32'(rd) * 32'h800
                + 32'(sh) * 32'h40 + 32'(func_tab[op]);
            return {1'b1, w};
        end
        if (op == 23 || op == 24) begin
            w = 32'(opc_tab[op]) * 32'h4000000 + 32'(imm);
            return {1'b0, w};
        end
        if (op <= 28) begin
            w = 32'(opc_tab[op]) * 32'h4000000 + 32'(rs) * 32'h200000 + 32'(rt) * 32'h10000
                + 32'(imm % 65536);
            return {1'b0, w};
        end
        return 33'h0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        check("count", 32'(count), 32'(mq.size()));
        check("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        check("err", 32'(err), 32'(err_m));
        if (mq.size() > 0) begin
            check("out_word", out_word, mq[0][31:0]);
            check("out_rtype", 32'(out_rtype), 32'(mq[0][32]));
        end
    endtask

    // One clock with the current inputs; model updated and compared #1 after the edge.
    task automatic cycle();
        bit acc, pp;
        logic [32:0] e;
        acc = in_valid && (mq.size() < DEPTH);
        pp  = out_ready && (mq.size() > 0);
        e   = ref_enc(int'(in_op), int'(in_rs), int'(in_rt), int'(in_rd), in_imm);
        @(posedge clk);
        #1;
        if (pp) void'(mq.pop_front());
        if (acc) begin
            if (trap_en && in_op > 5'd28) err_m = 1'b1;
            else mq.push_back(e);
        end
        check_state();
    endtask

    task automatic set_req(input int op, input int rs, input int rt, input int rd,
                           input logic [25:0] imm);
        in_valid = 1'b1;
        in_op = 5'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
        in_imm = imm;
    endtask

    task automatic rand_req(input int max_op);
        set_req($urandom_range(0, max_op), $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(0, 31), 26'($urandom));
    endtask

    initial begin
`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
        trap_en = 1'b1;
`else
        trap_en = 1'b0;
`endif
        // Reset values
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_word", out_word, 32'h0);
        check("rst_out_rtype", 32'(out_rtype), 32'h0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;

        // add r3, r1, r2
        set_req(0, 1, 2, 3, 26'h0);
        cycle();
        in_valid = 1'b0;
        check("add_word", out_word, 32'h00221820);
        check("add_rtype", 32'(out_rtype), 32'h1);
        check("add_count", 32'(count), 32'h1);
        out_ready = 1'b1;
        cycle();

        // addi then jal in order
        set_req(13, 4, 5, 0, 26'h0010);
        cycle();
        check("addi_word", out_word, 32'h8C850010);
        check("addi_rtype", 32'(out_rtype), 32'h0);
        set_req(24, 0, 0, 0, 26'h0000100);
        cycle();
        in_valid = 1'b0;
        check("jal_word", out_word, 32'hF8000100);
        check("jal_rtype", 32'(out_rtype), 32'h0);
        cycle();

        // Fill with out_ready low; 5th request held
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand_req(28);
            cycle();
        end
        check("full_in_ready", 32'(in_ready), 32'h0);
        check("full_count", 32'(count), 32'h4);
        rand_req(28);
        cycle();
        check("held_count", 32'(count), 32'h4);
        out_ready = 1'b1;
        cycle();
        check("pop_only_count", 32'(count), 32'h3);
        out_ready = 1'b0;
        cycle();
        check("held_push_count", 32'(count), 32'h4);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) cycle();

        // Illegal op
        out_ready = 1'b0;
        set_req(29, 7, 7, 7, 26'h3FFFFFF);
        cycle();
        in_valid = 1'b0;
        cycle();
        check("illegal_count", 32'(count), trap_en ? 32'h0 : 32'h1);
        check("illegal_err", 32'(err), trap_en ? 32'h1 : 32'h0);
        if (!trap_en) check("illegal_word", out_word, 32'h0);
        out_ready = 1'b1;
        cycle();
        check("err_sticky", 32'(err), trap_en ? 32'h1 : 32'h0);

        // Random traffic including illegal ops
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) rand_req(31);
            else in_valid = 1'b0;
            out_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end

        // Reset with 3 entries queued
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_req(28);
            cycle();
        end
        in_valid = 1'b0;
        check("pre_rst_count", 32'(count), 32'h3);
        #2;
        rst = 1'b1;
        #1;
        mq.delete();
        err_m = 1'b0;
        check("mid_rst_out_valid", 32'(out_valid), 32'h0);
        check("mid_rst_count", 32'(count), 32'h0);
        check("mid_rst_err", 32'(err), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        set_req(11, 9, 10, 11, 26'h0);
        cycle();
        in_valid = 1'b0;
        check("post_rst_count", 32'(count), 32'h1);
        check("post_rst_word", out_word, 32'h012A583A);
        out_ready = 1'b1;
        cycle();
        check("post_rst_alone", 32'(out_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Buffered instruction encoder: the inverse of the ALU-control decode path. Accepts an internal operation index (0–28, the same `res` codes the ALU control produces) plus operand fields over a valid/ready handshake. Assembles the 32-bit instruction word (R-type opcode/func or I/J-type opcode) and queues it in a small FIFO for a downstream consumer (instruction memory loader or self-test stimulus generator) over a second valid/ready handshake.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `CW`, 3, count width, = clog2(DEPTH)+1
- `clk` input 1: single clock, rising edge
- `rst` input 1: asynchronous, active-high reset
- `in_valid` input 1: request present
- `in_ready` output 1: encoder can accept
- `in_op` input 5: operation index 0–28
- `in_rs`, `in_rt`, `in_rd` input 5 each: register fields
- `in_imm` input 26: immediate/target
  - [15:0] I-type imm
  - [25:0] J-type target
  - [4:0] shamt for shifts
- `out_valid` output 1: head word valid
- `out_ready` input 1: consumer takes word
- `out_word` output 32: encoded instruction at FIFO head
- `out_rtype` output 1: head word is R-type
- `count` output CW: occupied entries
- `err` output 1: sticky illegal-op flag (macro-dependent)

## Operation
- Accept on `in_valid && in_ready`; pop on `out_valid && out_ready`.
- `in_ready = !full`. No pop-through: when full, a same-cycle pop does not enable a push.
- R-type ops 0–12:
  - word = {6'b000000, rs, rt, rd, shamt, func}
  - shamt = `in_imm[4:0]` for ops 3–6, else 0
  - func: add 100000, sub 100010, mul 100101, sl 000111, sr 000110, sla 110100, sra 110110, jr 000001, mov 000011, and 111000, or 111001, xor 111010, slt 110011
- I-type ops 13–22 and 25–28:
  - word = {opcode, rs, rt, imm[15:0]}
  - opcode: addi 100011, subi 110001, muli 111000, lw 010001, sw 011001, beq 100000, brg 100010, brl 100101, bne 000111, brz 000110, andi 001111, ori 001110, xori 001100, slti 001000
- J-type ops 23–24:
  - word = {opcode, imm[25:0]}
  - opcode: jmp 110100, jal 111110
- `out_rtype` is stored with each entry.
- Illegal op 29–31: handling per Configuration.
- Simultaneous push and pop when not full and not empty: both occur, `count` unchanged.
- Pointers wrap modulo DEPTH.

## Timing
- Reset values (asynchronous, immediate):
  - `out_valid`=0, `out_word`=0, `out_rtype`=0, `count`=0, `err`=0, `in_ready`=1
  - pointers = 0
- Latency: word accepted at edge N appears on `out_word` with `out_valid`=1 after edge N (one cycle) when the FIFO was empty.
- `out_word` and `out_rtype` hold stable while `out_valid && !out_ready`.
- `count` updates on the edge of the push/pop.
- Reset mid-operation flushes all entries. No partial word is ever emitted.

## Configuration
- `INSTR_ENC_ILLEGAL_TRAP_EN` defined:
  - illegal op is accepted (handshake completes) but not written
  - `err` sets on the following edge and stays set until `rst`
- Macro undefined:
  - illegal op is encoded as 32'h00000000 (NOP) with `out_rtype`=0 and queued normally
  - `err` is tied 0

## Structure
- Shared package `cpu_isa_pkg`:
  - op index localparams (OP_ADD=0 … OP_SLTI=28)
  - 6-bit opcode and func constants
  - R-type opcode 6'b000000
  - field position constants
  - the same constants serve the ALU control decoder
- Encode function lives in the package as a pure function.
- One sub-module `instr_enc_fifo`: synchronous FIFO, parameters DEPTH/width, async active-high reset, full/empty/count.

## Test plan
- Reset, then op=0, rs=1, rt=2, rd=3 -> one cycle later `out_word`=0x00221820, `out_rtype`=1, `count`=1.
- op=13, rs=4, rt=5, imm=0x0010, then op=24, imm=0x0000100, with `out_ready`=1 -> words 0x8C850010 then 0xF8000100, in order, `out_rtype`=0.
- Hold `out_ready`=0 and push 5 requests with DEPTH=4 -> `in_ready` drops after the 4th; `count`=4; 5th held; drain order matches push order.
- Full FIFO with `out_ready`=1 and `in_valid`=1 in the same cycle -> pop only, `count`=3; push accepted next cycle.
- op=29:
  - with macro: no word queued, `err`=1 and sticky
  - without macro: 0x00000000 queued, `err`=0
- Assert `rst` with 3 entries queued -> `out_valid`=0 and `count`=0 immediately; first post-reset push appears alone.
